// File: rtl/serial_pkg.sv
// Shared definitions for the two-wire serial master/receiver pair.
package serial_pkg;

    localparam int DEF_MESSAGE_LENGTH = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        RECEIVE = 1'b1
    } state_t;

    // Counter width for indexing n bits; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_MESSAGE_LENGTH);

endpackage

// File: rtl/line_sync.sv
// Multi-flop synchroniser for one bus line plus a history flop for edge detection.
module line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic s,
    output logic p
);

    logic [SYNC_STAGES-1:0] chain;

    // Both lines idle high, so resetting to 1 keeps reset release event-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '1;
            p     <= 1'b1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
            p     <= chain[SYNC_STAGES-1];
        end
    end

    assign s = chain[SYNC_STAGES-1];

endmodule

// File: rtl/serial_receiver.sv
// Recovers LSB-first words from the sda/scl bus and presents them on a one-entry valid/ready register.
module serial_receiver
    import serial_pkg::*;
#(
    parameter int MESSAGE_LENGTH = DEF_MESSAGE_LENGTH,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sda,
    input  logic                      scl,
    output logic [MESSAGE_LENGTH-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      overrun,
    output logic                      frame_err
);

    localparam int CNT_W = cnt_width(MESSAGE_LENGTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(MESSAGE_LENGTH - 1);

    logic sda_s, sda_p, scl_s, scl_p;
    logic start_ev, stop_ev, bit_ev;

    state_t                    state, state_n;
    logic [CNT_W-1:0]          bit_cnt, bit_cnt_n;
    logic [MESSAGE_LENGTH-1:0] shift, shift_n;
    logic                      word_done;
    logic                      frame_err_n;

    line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk (clk),
        .rst (rst),
        .d   (sda),
        .s   (sda_s),
        .p   (sda_p)
    );

    line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk (clk),
        .rst (rst),
        .d   (scl),
        .s   (scl_s),
        .p   (scl_p)
    );

    // START/STOP need scl steady high across both samples, so they can never
    // coincide with a BIT event.
    assign start_ev = scl_s && scl_p &&  sda_p && !sda_s;
    assign stop_ev  = scl_s && scl_p && !sda_p &&  sda_s;
    assign bit_ev   = scl_s && !scl_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        word_done   = 1'b0;
        frame_err_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_ev) begin
                    state_n   = RECEIVE;
                    bit_cnt_n = '0;
                    shift_n   = '0;
                end
            end
            RECEIVE: begin
                if (stop_ev) begin
                    state_n     = IDLE;
                    frame_err_n = (bit_cnt != '0);
                    bit_cnt_n   = '0;
                    shift_n     = '0;
                end else if (start_ev) begin
                    frame_err_n = (bit_cnt != '0);
                    bit_cnt_n   = '0;
                    shift_n     = '0;
                end else if (bit_ev) begin
                    shift_n[bit_cnt] = sda_s;
                    if (bit_cnt == LAST_BIT) begin
                        word_done = 1'b1;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A completing word can replace the current one only if it is being consumed this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            frame_err <= frame_err_n;
            if (word_done) begin
                if (!out_valid || out_ready) begin
                    out_data  <= shift_n;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = (state == RECEIVE);

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver: drives the bus like the master and checks words and flags.
module tb_serial_receiver;

    localparam int H = 4;   // clk cycles per bus phase, >= SYNC_STAGES+1

    logic       clk = 1'b0;
    logic       rst;
    logic       sda;
    logic       scl;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       overrun;
    logic       frame_err;

    int n_cmp = 0;
    int n_err = 0;

    int ov_cnt = 0;
    int fe_cnt = 0;
    int acc_cnt = 0;
    logic [7:0] acc_data = 8'h00;
    int ov0, fe0, acc0;

    serial_receiver dut (
        .clk       (clk),
        .rst       (rst),
        .sda       (sda),
        .scl       (scl),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Counts flag pulses and accepted words, sampled mid-cycle.
    always @(negedge clk) begin
        if (overrun)   ov_cnt <= ov_cnt + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (out_valid && out_ready) begin
            acc_cnt  <= acc_cnt + 1;
            acc_data <= out_data;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        ov0  = ov_cnt;
        fe0  = fe_cnt;
        acc0 = acc_cnt;
    endtask

    // Expects scl high.
    task automatic do_start();
        sda = 1'b1; cyc(H);
        sda = 1'b0; cyc(H);
    endtask

    // Expects scl high; a high sda first becomes a repeated start.
    task automatic do_stop();
        sda = 1'b0; cyc(H);
        sda = 1'b1; cyc(H);
    endtask

    // Leaves scl high after the rising edge.
    task automatic put_bit(input logic b);
        scl = 1'b0; cyc(H);
        sda = b;    cyc(H);
        scl = 1'b1; cyc(H);
    endtask

    task automatic send(input logic [7:0] v);
        for (int i = 0; i < 8; i++) put_bit(v[i]);
    endtask

    initial begin
        rst = 1'b1; sda = 1'b1; scl = 1'b1; out_ready = 1'b0;
        cyc(3);
        chk("rst_data",  32'(out_data),  32'h00);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_busy",  32'(busy),      32'h0);
        chk("rst_ovr",   32'(overrun),   32'h0);
        chk("rst_ferr",  32'(frame_err), 32'h0);
        rst = 1'b0;
        cyc(50);
        chk("idle_valid", 32'(out_valid), 32'h0);
        chk("idle_busy",  32'(busy),      32'h0);
        chk("idle_flags", 32'(ov_cnt + fe_cnt + acc_cnt), 32'h0);

        // Single word, consumer always ready.
        out_ready = 1'b1; snap();
        do_start();
        chk("a5_busy", 32'(busy), 32'h1);
        send(8'hA5);
        chk("a5_acc",   32'(acc_cnt - acc0), 32'h1);
        chk("a5_data",  32'(acc_data),       32'hA5);
        chk("a5_vclr",  32'(out_valid),      32'h0);
        do_stop();
        chk("a5_idle",  32'(busy),           32'h0);
        chk("a5_flags", 32'(ov_cnt - ov0 + fe_cnt - fe0), 32'h0);

        // Back-to-back words with the consumer stalled.
        out_ready = 1'b0; snap();
        do_start();
        send(8'h3C);
        chk("3c_valid", 32'(out_valid), 32'h1);
        chk("3c_data",  32'(out_data),  32'h3C);
        send(8'hC3);
        chk("c3_held",  32'(out_data),  32'h3C);
        chk("c3_ovr",   32'(ov_cnt - ov0), 32'h1);
        do_stop();
        chk("c3_idle",  32'(busy), 32'h0);
        out_ready = 1'b1;
        cyc(1);
        chk("c3_vclr",  32'(out_valid), 32'h0);
        chk("c3_acc",   32'(acc_cnt - acc0), 32'h1);
        chk("c3_accd",  32'(acc_data), 32'h3C);
        chk("c3_ovr1",  32'(ov_cnt - ov0), 32'h1);

        // Framing errors: STOP after 3 bits, START after 5 bits.
        snap();
        do_start();
        put_bit(1'b1); put_bit(1'b1); put_bit(1'b0);
        do_stop();
        chk("fe_stop",  32'(fe_cnt - fe0), 32'h1);
        chk("fe_idle",  32'(busy),         32'h0);
        chk("fe_vld",   32'(out_valid),    32'h0);
        do_start();
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
        do_start();
        chk("fe_start", 32'(fe_cnt - fe0), 32'h2);
        chk("fe_busy",  32'(busy),         32'h1);
        send(8'h81);
        chk("81_acc",   32'(acc_cnt - acc0), 32'h1);
        chk("81_data",  32'(acc_data),       32'h81);
        do_stop();
        chk("81_fe",    32'(fe_cnt - fe0), 32'h2);
        chk("81_idle",  32'(busy),         32'h0);

        // Completion in the same cycle the held word is consumed.
        out_ready = 1'b0; snap();
        do_start();
        send(8'h5A);
        chk("5a_valid", 32'(out_valid), 32'h1);
        chk("5a_data",  32'(out_data),  32'h5A);
        for (int i = 0; i < 7; i++) put_bit(1'(8'h69 >> i));
        scl = 1'b0; cyc(H);
        sda = 1'b0; cyc(H);
        scl = 1'b1; cyc(2);
        out_ready = 1'b1; cyc(1);
        out_ready = 1'b0;
        chk("69_valid", 32'(out_valid), 32'h1);
        chk("69_data",  32'(out_data),  32'h69);
        chk("69_ovr",   32'(ov_cnt - ov0), 32'h0);
        chk("69_acc",   32'(acc_cnt - acc0), 32'h1);
        chk("69_accd",  32'(acc_data), 32'h5A);
        cyc(H);
        do_stop();
        out_ready = 1'b1; cyc(2);
        chk("69_vclr",  32'(out_valid), 32'h0);
        chk("69_acc2",  32'(acc_data),  32'h69);

        // Reset mid-word with a held word, then a clean frame.
        out_ready = 1'b0;
        do_start();
        send(8'h77);
        put_bit(1'b1); put_bit(1'b1); put_bit(1'b1); put_bit(1'b1);
        chk("pre_rst_v", 32'(out_valid), 32'h1);
        rst = 1'b1; cyc(1);
        chk("mrst_valid", 32'(out_valid), 32'h0);
        chk("mrst_data",  32'(out_data),  32'h00);
        chk("mrst_busy",  32'(busy),      32'h0);
        chk("mrst_flags", 32'({overrun, frame_err}), 32'h0);
        cyc(2);
        rst = 1'b0; cyc(2);
        out_ready = 1'b1; snap();
        do_start();
        send(8'h12);
        do_stop();
        chk("12_acc",   32'(acc_cnt - acc0), 32'h1);
        chk("12_data",  32'(acc_data),       32'h12);
        chk("12_flags", 32'(ov_cnt - ov0 + fe_cnt - fe0), 32'h0);
        chk("12_idle",  32'(busy),           32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
